// File: rtl/turnstile_passage_responder.sv
// Turnstile passage responder.
// Accepts an enter/exit grant from the gate controller, confirms one physical
// passage through the debounced rotation sensor, tracks room occupancy and
// shows it on a 7-segment digit. A completion or timeout is returned as a
// one-cycle pulse.
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   ENTER_REQ/EXIT_REQ  granted direction, level
//   KEY                 raw rotation sensor, active-low, asynchronous
//   PASS_DONE/TIMEOUT   one-cycle result pulses
//   PASS_DIR            direction of last accepted grant (1 = enter)
//   BUSY                passage in progress (armed or rotating)
//   OCC / HEX0          occupancy and its active-low 7-seg image (a..g = [6:0])
//   LEDG / LEDR         holding after passage / fault
module turnstile_passage_responder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned MAX_OCC         = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENTER_REQ,
    input  logic       EXIT_REQ,
    input  logic       KEY,
    output logic       PASS_DONE,
    output logic       PASS_DIR,
    output logic       TIMEOUT,
    output logic       BUSY,
    output logic [3:0] OCC,
    output logic [6:0] HEX0,
    output logic       LEDG,
    output logic       LEDR
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TM_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned OCC_W = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_ROTATING = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [DB_W-1:0]  dbc_q, dbc_d;
    logic [2:0]       state_q, state_d;
    logic [TM_W-1:0]  tmr_q, tmr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic             busy_q, busy_d;
    logic             ledg_q, ledg_d;
    logic             ledr_q, ledr_d;
    logic [6:0]       hex_q, hex_d;

    logic press_c, release_c, tmr_exp_c, granted_c;

    // Active-low 7-seg pattern, segment a in bit 6.
    function automatic logic [6:0] seg_of(input logic [OCC_W-1:0] v);
        case (v)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Sensor synchronizer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        dbc_d = dbc_q;
        if (sync2_q == db_q) begin
            dbc_d = '0;
        end else if (dbc_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = sync2_q;
            dbc_d = '0;
        end else begin
            dbc_d = dbc_q + DB_W'(1);
        end
    end

    // Edges are taken from the debounced level as it changes.
    assign press_c   = db_q & ~db_d;
    assign release_c = ~db_q & db_d;
    assign tmr_exp_c = (tmr_q == TM_W'(TIMEOUT_CYCLES - 1));
    assign granted_c = dir_q ? ENTER_REQ : EXIT_REQ;

    // Passage FSM next-state and registered outputs.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        occ_d   = occ_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ENTER_REQ && EXIT_REQ) begin
                    state_d = S_FAULT;
                end else if (ENTER_REQ) begin
                    if (occ_q < OCC_W'(MAX_OCC)) begin
                        state_d = S_ARMED;
                        dir_d   = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        state_d = S_FAULT;
                    end
                end else if (EXIT_REQ) begin
                    if (occ_q != '0) begin
                        state_d = S_ARMED;
                        dir_d   = 1'b0;
                        tmr_d   = '0;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_ARMED: begin
                tmr_d = tmr_q + TM_W'(1);
                if (tmr_exp_c) begin
                    state_d = S_FAULT;
                    tmo_d   = 1'b1;
                end else if (!granted_c) begin
                    state_d = S_IDLE;
                end else if (press_c) begin
                    state_d = S_ROTATING;
                end
            end
            S_ROTATING: begin
                tmr_d = tmr_q + TM_W'(1);
                if (tmr_exp_c) begin
                    state_d = S_FAULT;
                    tmo_d   = 1'b1;
                end else if (release_c) begin
                    state_d = S_HOLD;
                    done_d  = 1'b1;
                    occ_d   = dir_q ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
                end
            end
            S_HOLD, S_FAULT: begin
                if (!ENTER_REQ && !EXIT_REQ) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_ARMED) || (state_d == S_ROTATING);
        ledg_d = (state_d == S_HOLD);
        ledr_d = (state_d == S_FAULT);
        hex_d  = seg_of(occ_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_q    <= 1'b1;
            dbc_q   <= '0;
            state_q <= S_IDLE;
            tmr_q   <= '0;
            occ_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            ledg_q  <= 1'b0;
            ledr_q  <= 1'b0;
            hex_q   <= 7'b0000001;
        end else begin
            db_q    <= db_d;
            dbc_q   <= dbc_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            occ_q   <= occ_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            ledg_q  <= ledg_d;
            ledr_q  <= ledr_d;
            hex_q   <= hex_d;
        end
    end

    assign PASS_DONE = done_q;
    assign PASS_DIR  = dir_q;
    assign TIMEOUT   = tmo_q;
    assign BUSY      = busy_q;
    assign OCC       = occ_q;
    assign HEX0      = hex_q;
    assign LEDG      = ledg_q;
    assign LEDR      = ledr_q;

endmodule

// File: tb/tb_turnstile_passage_responder.sv
// Bench for turnstile_passage_responder: directed scenarios plus random
// stimulus, checked each cycle against a behavioural model of the passage rules.
module tb_turnstile_passage_responder;

    localparam int DEB = 4;
    localparam int TMO = 64;
    localparam int MAXO = 9;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ENTER_REQ = 1'b0;
    logic       EXIT_REQ = 1'b0;
    logic       KEY = 1'b1;
    logic       PASS_DONE, PASS_DIR, TIMEOUT, BUSY, LEDG, LEDR;
    logic [3:0] OCC;
    logic [6:0] HEX0;

    int n_vec = 0;
    int n_err = 0;

    turnstile_passage_responder #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO),
        .MAX_OCC        (MAXO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENTER_REQ(ENTER_REQ),
        .EXIT_REQ (EXIT_REQ),
        .KEY      (KEY),
        .PASS_DONE(PASS_DONE),
        .PASS_DIR (PASS_DIR),
        .TIMEOUT  (TIMEOUT),
        .BUSY     (BUSY),
        .OCC      (OCC),
        .HEX0     (HEX0),
        .LEDG     (LEDG),
        .LEDR     (LEDR)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    // Phases: 0 idle, 1 armed, 2 rotating, 3 holding, 4 fault.
    logic [6:0] hex_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};
    bit       m_valid = 0;
    int       m_phase = 0;
    int       m_age = 0;
    int       m_occ = 0;
    bit       m_dir = 0;
    bit       m_done = 0;
    bit       m_tmo = 0;
    logic [6:0] m_hex = 7'b0000001;
    bit       m_s1 = 1, m_s2 = 1, m_db = 1;
    bit [DEB-1:0] m_win = '1;
    bit       m_smp, m_press, m_rel, m_granted;

    always @(posedge CLK) begin
        if (RST) begin
            m_phase = 0; m_age = 0; m_occ = 0; m_dir = 0;
            m_done = 0; m_tmo = 0; m_hex = 7'b0000001;
            m_s1 = 1; m_s2 = 1; m_db = 1; m_win = '1;
        end else begin
            // sensor: two-stage sync delay, then a DEB-sample agreement window
            m_smp = m_s2; m_s2 = m_s1; m_s1 = KEY;
            m_win = {m_win[DEB-2:0], m_smp};
            m_press = 0; m_rel = 0;
            if (m_win == {DEB{~m_db}}) begin
                m_db = ~m_db;
                m_press = ~m_db;
                m_rel = m_db;
            end
            m_hex = hex_tab[m_occ];
            m_done = 0; m_tmo = 0;
            m_granted = m_dir ? ENTER_REQ : EXIT_REQ;
            case (m_phase)
                0: begin
                    if (ENTER_REQ && EXIT_REQ) m_phase = 4;
                    else if (ENTER_REQ) begin
                        if (m_occ < MAXO) begin m_phase = 1; m_dir = 1; m_age = 0; end
                        else m_phase = 4;
                    end else if (EXIT_REQ) begin
                        if (m_occ > 0) begin m_phase = 1; m_dir = 0; m_age = 0; end
                        else m_phase = 4;
                    end
                end
                1, 2: begin
                    m_age++;
                    if (m_age == TMO) begin m_phase = 4; m_tmo = 1; end
                    else if (m_phase == 1 && !m_granted) m_phase = 0;
                    else if (m_phase == 1 && m_press) m_phase = 2;
                    else if (m_phase == 2 && m_rel) begin
                        m_phase = 3; m_done = 1;
                        m_occ = m_dir ? m_occ + 1 : m_occ - 1;
                    end
                end
                default: if (!ENTER_REQ && !EXIT_REQ) m_phase = 0;
            endcase
        end
        m_valid = 1;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("pass_done", int'(PASS_DONE), int'(m_done));
        chk("pass_dir",  int'(PASS_DIR),  int'(m_dir));
        chk("timeout",   int'(TIMEOUT),   int'(m_tmo));
        chk("busy",      int'(BUSY),      int'(m_phase == 1 || m_phase == 2));
        chk("occ",       int'(OCC),       m_occ);
        chk("hex0",      int'(HEX0),      int'(m_hex));
        chk("ledg",      int'(LEDG),      int'(m_phase == 3));
        chk("ledr",      int'(LEDR),      int'(m_phase == 4));
    endtask

    // Advance n cycles; model compare at each falling edge, inputs change just after.
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (m_valid) compare_model();
            #1;
        end
    endtask

    task automatic passage(input bit enter);
        ENTER_REQ = enter; EXIT_REQ = ~enter;
        cyc(1);
        KEY = 0; cyc(8);
        KEY = 1; cyc(8);
        ENTER_REQ = 0; EXIT_REQ = 0;
        cyc(2);
    endtask

    int k, guard, sel;

    initial begin
        RST = 1; cyc(3);
        chk("reset_hex", int'(HEX0), 7'b0000001);
        chk("reset_occ", int'(OCC), 0);
        RST = 0; cyc(2);

        // exit from empty room
        EXIT_REQ = 1; cyc(2);
        chk("empty_exit_ledr", int'(LEDR), 1);
        chk("empty_exit_occ", int'(OCC), 0);
        EXIT_REQ = 0; cyc(2);
        chk("empty_exit_clear", int'(LEDR), 0);

        // single entry, then extra press while grant held
        ENTER_REQ = 1; cyc(2);
        KEY = 0; cyc(20);
        KEY = 1; cyc(10);
        chk("entry_occ", int'(OCC), 1);
        chk("entry_hex", int'(HEX0), 7'b1001111);
        chk("entry_ledg", int'(LEDG), 1);
        KEY = 0; cyc(10);
        KEY = 1; cyc(10);
        chk("entry_no_recount", int'(OCC), 1);
        ENTER_REQ = 0; cyc(2);

        // bounce rejection then real rotation
        ENTER_REQ = 1; cyc(2);
        for (int w = 1; w <= 3; w++) begin
            KEY = 0; cyc(w);
            KEY = 1; cyc(4);
            chk("bounce_busy", int'(BUSY), 1);
        end
        KEY = 0; cyc(6);
        KEY = 1; cyc(8);
        chk("bounce_then_pass", int'(OCC), 2);
        ENTER_REQ = 0; cyc(2);

        // fill the room, then an entry must fault
        guard = 0;
        while (m_occ < MAXO && guard < 20) begin passage(1); guard++; end
        ENTER_REQ = 1; cyc(2);
        chk("full_ledr", int'(LEDR), 1);
        chk("full_occ", int'(OCC), 9);
        chk("full_hex", int'(HEX0), 7'b0000100);
        ENTER_REQ = 0; cyc(2);

        repeat (6) passage(0);
        chk("after_exits_occ", int'(OCC), 3);

        // timeout measured from arming
        ENTER_REQ = 1; KEY = 1;
        k = 0;
        while (!BUSY && k < 10) begin cyc(1); k++; end
        k = 0;
        while (!TIMEOUT && k < 200) begin cyc(1); k++; end
        chk("timeout_latency", k, 64);
        cyc(1);
        chk("timeout_single", int'(TIMEOUT), 0);
        chk("timeout_occ", int'(OCC), 3);
        ENTER_REQ = 0; cyc(2);

        // conflicting grants
        ENTER_REQ = 1; EXIT_REQ = 1; cyc(2);
        chk("conflict_ledr", int'(LEDR), 1);
        ENTER_REQ = 0; EXIT_REQ = 0; cyc(2);

        // reset while rotating
        ENTER_REQ = 1; cyc(1);
        KEY = 0; cyc(10);
        chk("rot_busy", int'(BUSY), 1);
        RST = 1; #1;
        chk("rst_mid_occ", int'(OCC), 0);
        chk("rst_mid_hex", int'(HEX0), 7'b0000001);
        chk("rst_mid_busy", int'(BUSY), 0);
        cyc(2);
        KEY = 1; ENTER_REQ = 0; RST = 0;
        cyc(4);
        chk("rst_mid_nodone", int'(PASS_DONE), 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 4)      begin ENTER_REQ = 0; EXIT_REQ = 0; end
                else if (sel < 7) begin ENTER_REQ = 1; EXIT_REQ = 0; end
                else if (sel < 9) begin ENTER_REQ = 0; EXIT_REQ = 1; end
                else              begin ENTER_REQ = 1; EXIT_REQ = 1; end
            end
            if ($urandom_range(0, 5) == 0) KEY = ~KEY;
            RST = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        RST = 0; cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
